// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the constant-fetch state encoding.
package cpu_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 20;
  localparam int OFF_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Loadable/clearable up-counter with a terminal-count flag at TIMEOUT-1.
module fetch_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(TIMEOUT - 1));

  // Saturates at terminal count so a stalled owner never sees the counter wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/const_fetch.sv
// Constant-pool fetch: base+offset address, single-outstanding memory read,
// bounded by a timeout, returns data or error to the requester.
module const_fetch #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int OFF_W   = cpu_pkg::OFF_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFF_W-1:0]  req_offset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  import cpu_pkg::*;

  fetch_state_t    state;
  logic [ADDR_W:0] sum;
  logic            accept;
  logic            timer_clear;
  logic            timer_enable;
  logic            timer_tc;

  // Carry out of the extra top bit flags a pool address past the end of memory.
  assign sum    = {1'b0, base_addr} + {{(ADDR_W + 1 - OFF_W){1'b0}}, req_offset};
  assign accept = req_valid && req_ready;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  assign timer_clear  = (state == IDLE) || ((state == ISSUE) && mem_gnt);
  assign timer_enable = (state == ISSUE) || (state == WAIT);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .load     (1'b0),
    .load_val ('0),
    .enable   (timer_enable),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sum[ADDR_W]) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= RESP;
            end else begin
              mem_addr <= sum[ADDR_W-1:0];
              mem_req  <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A grant on the terminal-count cycle still wins.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end else if (timer_tc) begin
            mem_req  <= 1'b0;
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            state    <= RESP;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rsp_data <= mem_rdata;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (timer_tc) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_const_fetch.sv
// Self-checking bench for const_fetch: directed cases plus randomized fetches
// checked against a cycle-schedule model derived from the fetch rules.
module tb_const_fetch;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] base_addr;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_offset;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [19:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_data;
  logic        rsp_err;

  int compared   = 0;
  int mismatched = 0;

  const_fetch #(
    .ADDR_W  (20),
    .DATA_W  (20),
    .OFF_W   (12),
    .TIMEOUT (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete fetch. g = ISSUE cycles before grant, r = WAIT cycles before
  // rvalid, hold = cycles of response backpressure.
  task automatic run_fetch(input logic [19:0] base, input logic [11:0] off,
                           input int g, input int r, input logic [19:0] data,
                           input int hold);
    logic [20:0] sum;
    bit          wrap;
    bit          exp_err;
    logic [19:0] exp_data;
    int          exp_cyc;
    int          gnt_cyc;
    int          rv_cyc;
    int          issue_end;
    bit          in_issue;

    sum     = {1'b0, base} + {9'b0, off};
    wrap    = sum[20];
    gnt_cyc = -1;
    rv_cyc  = -1;
    if (wrap) begin
      exp_cyc = 1; exp_err = 1'b1; exp_data = 20'h0;
    end else if (g > T - 1) begin
      exp_cyc = 1 + T; exp_err = 1'b1; exp_data = 20'h0;
    end else begin
      gnt_cyc = 1 + g;
      if (r <= T - 1) begin
        rv_cyc = 2 + g + r; exp_cyc = 3 + g + r; exp_err = 1'b0; exp_data = data;
      end else begin
        exp_cyc = 2 + g + T; exp_err = 1'b1; exp_data = 20'h0;
      end
    end
    issue_end = (gnt_cyc > 0) ? gnt_cyc : T;

    base_addr  = base;
    req_offset = off;
    req_valid  = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    tick;
    req_valid  = 1'b0;
    req_offset = 12'($urandom);
    base_addr  = 20'($urandom);

    for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
      if (cyc < exp_cyc) begin
        check("rsp_valid_busy", 32'(rsp_valid), 32'd0);
        check("req_ready_busy", 32'(req_ready), 32'd0);
      end else begin
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
      end
      in_issue = !wrap && (cyc <= issue_end);
      if (wrap) begin
        check("mem_req_wrap", 32'(mem_req), 32'd0);
      end else if (in_issue) begin
        check("mem_req_issue", 32'(mem_req), 32'd1);
        check("mem_addr_issue", 32'(mem_addr), 32'(sum[19:0]));
      end else begin
        check("mem_req_dropped", 32'(mem_req), 32'd0);
      end
      if (cyc < exp_cyc) begin
        mem_gnt    = (cyc == gnt_cyc);
        mem_rvalid = (cyc == rv_cyc) || (in_issue && ($urandom_range(0, 1) == 1));
        mem_rdata  = (cyc == rv_cyc) ? data : 20'($urandom);
        tick;
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      tick;
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_data_hold", 32'(rsp_data), 32'(exp_data));
      check("rsp_err_hold", 32'(rsp_err), 32'(exp_err));
      check("req_ready_hold", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    $display("fetch base=%05h off=%03h g=%0d r=%0d hold=%0d -> data=%05h err=%0b lat=%0d",
             base, off, g, r, hold, exp_data, exp_err, exp_cyc);
  endtask

  initial begin
    reset      = 1'b0;
    base_addr  = '0;
    req_valid  = 1'b0;
    req_offset = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rsp_ready  = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick;

    // Basic, wrap and last-address fetches.
    run_fetch(20'h01000, 12'h004, 0, 0, 20'hABCDE, 0);
    run_fetch(20'hFFFF0, 12'h020, 0, 0, 20'h12345, 1);
    run_fetch(20'hFFFF0, 12'h00F, 0, 1, 20'h5A5A5, 0);
    // Grant stall and response backpressure.
    run_fetch(20'h02000, 12'h0FF, 5, 2, 20'h0F00D, 3);
    // WAIT timeout, then a late rvalid in IDLE must be ignored.
    run_fetch(20'h03000, 12'h010, 0, 100, 20'hBEEF1, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 20'h77777;
    tick;
    mem_rvalid = 1'b0;
    check("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
    check("late_rvalid_ready", 32'(req_ready), 32'd1);
    run_fetch(20'h03000, 12'h011, 1, 1, 20'h13579, 0);
    // Grant timeout and rvalid/terminal-count collision.
    run_fetch(20'h04000, 12'h001, T + 2, 0, 20'h22222, 0);
    run_fetch(20'h05000, 12'h002, 0, T - 1, 20'h00055, 0);

    // Asynchronous reset while in WAIT drops the fetch.
    base_addr  = 20'h00100;
    req_offset = 12'h001;
    req_valid  = 1'b1;
    tick;
    req_valid  = 1'b0;
    mem_gnt    = 1'b1;
    tick;
    mem_gnt    = 1'b0;
    tick;
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data", 32'(rsp_data), 32'd0);
    check("arst_rsp_err", 32'(rsp_err), 32'd0);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i == 0);
      tick;
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
    end
    mem_rvalid = 1'b0;
    $display("reset mid-WAIT: transaction dropped");

    // Randomized fetches, biased toward the top of memory for wrap coverage.
    for (int n = 0; n < 30; n++) begin
      logic [19:0] b;
      b = ($urandom_range(0, 3) == 0) ? (20'hFF000 | 20'($urandom_range(0, 4095)))
                                      : 20'($urandom);
      run_fetch(b, 12'($urandom), $urandom_range(0, T + 1), $urandom_range(0, T + 1),
                20'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
